thresh_loader: RTL and testbench
================================

THRESH_LOADER -- requirements
Module: thresh_loader

Interface
REQ-001 SHALL have parameter NBEAMS, default 2, number of beams per threshold cascade (2..64).
REQ-002 SHALL have parameter THRESH_BITS, default 18, width of one threshold word.
REQ-003 SHALL have port aclk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port stg_wr_i  input  1  staging write strobe, one word per cycle.
REQ-006 SHALL have port stg_sel_i  input  1  staging bank: 0 = trigger threshold, 1 = subthreshold.
REQ-007 SHALL have port stg_addr_i  input  clog2(NBEAMS)  staging beam index.
REQ-008 SHALL have port stg_dat_i  input  THRESH_BITS  staging write data.
REQ-009 SHALL have port load_i  input  1  single-cycle request to push staged thresholds into the cascade.
REQ-010 SHALL have port busy_o  output  1  high from the cycle after an accepted load until done_o.
REQ-011 SHALL have port done_o  output  1  single-cycle pulse when a load sequence completes.
REQ-012 SHALL have port thresh_o  output  2*THRESH_BITS  cascade data; [THRESH_BITS-1:0] trigger threshold, upper half subthreshold.
REQ-013 SHALL have port thresh_wr_o  output  2  cascade shift-up write strobes, bit 0 trigger threshold, bit 1 subthreshold.
REQ-014 SHALL have port thresh_update_o  output  2  cascade commit strobes, same bit mapping.
REQ-015 SHALL have ports rb_sel_i/rb_addr_i (inputs) and rb_dat_o (output, THRESH_BITS): staging readback.

Function
REQ-016 SHALL hold two staging memories, each NBEAMS x THRESH_BITS; a stg_wr_i write stores stg_dat_i at [stg_sel_i][stg_addr_i] at the next edge.
REQ-017 SHALL ignore staging writes with stg_addr_i >= NBEAMS.
REQ-018 SHALL implement FSM states IDLE, SHIFT, UPDATE, DONE.
REQ-019 IDLE -> SHIFT when load_i=1; beam counter is loaded with NBEAMS-1.
REQ-020 In SHIFT, each cycle SHALL drive thresh_wr_o=2'b11 with thresh_o={sub[cnt],thr[cnt]}, then decrement cnt; after cnt=0 -> UPDATE (exactly NBEAMS write cycles, highest beam first).
REQ-021 UPDATE SHALL drive thresh_update_o=2'b11 for exactly one cycle -> DONE.
REQ-022 DONE SHALL drive done_o=1 for one cycle -> IDLE, or -> SHIFT immediately when a reload is pending.
REQ-023 Latency: load_i at edge N -> first thresh_wr_o at N+1, last at N+NBEAMS, thresh_update_o at N+NBEAMS+1, done_o at N+NBEAMS+2.
REQ-024 thresh_wr_o and thresh_update_o SHALL never be asserted together; outside SHIFT/UPDATE both are 0 and thresh_o is 0.
REQ-025 load_i while busy SHALL set one pending flag; multiple such requests coalesce into one reload.
REQ-026 A staging write accepted while busy_o=1 SHALL also set the pending flag; same-cycle write and SHIFT read of one entry returns the old value.
REQ-027 Pending flag SHALL clear on the DONE -> SHIFT transition.
REQ-028 busy_o SHALL be 1 in SHIFT, UPDATE, DONE; 0 in IDLE.

Reset
REQ-029 aresetn=0 SHALL force IDLE, cnt=0, pending=0, busy_o=0, done_o=0, thresh_o=0, thresh_wr_o=0, thresh_update_o=0, rb_dat_o=0, asynchronously.
REQ-030 Reset mid-sequence SHALL abort with no further strobes; staging contents are not reset and are preserved.

Configuration
REQ-031 With THRESH_LOADER_READBACK_EN defined, rb_dat_o SHALL equal staging[rb_sel_i][rb_addr_i] one cycle after address is presented (registered); out-of-range address returns 0.
REQ-032 Without THRESH_LOADER_READBACK_EN, rb_dat_o SHALL be constant 0 and rb_sel_i/rb_addr_i are unused.

Verification
REQ-033 NBEAMS=2: write thr={0x100,0x101}, sub={0x200,0x201}, pulse load_i -> wr cycles carry {0x201,0x101} then {0x200,0x100}, update next cycle, done_o 4 cycles after load.
REQ-034 load_i pulsed 3 times during busy -> exactly one extra sequence immediately after done_o, no IDLE cycle between.
REQ-035 Staging write to beam 0 during SHIFT -> current sequence completes, second sequence shifts the new value.
REQ-036 aresetn dropped in SHIFT cycle 1 -> all outputs 0 same cycle; after release, load_i shifts previously staged data unchanged.
REQ-037 NBEAMS=46: write to addr 50 ignored, readback (macro on) of addr 45 returns last written value one cycle later.

Source files
------------

// File: rtl/thresh_loader.sv
// thresh_loader
//   Stages per-beam trigger and subthreshold words in two banks. On request it
//   shifts them into an external threshold cascade, highest beam first, and
//   then issues a commit strobe.
//
//   Optional feature: define THRESH_LOADER_READBACK_EN to enable registered
//   staging readback on rb_dat_o. Otherwise rb_dat_o is tied to 0.
//
//   Ports
//     aclk, aresetn          clock; asynchronous active-low reset
//     stg_wr_i/sel/addr/dat  staging write (sel 0 = trigger, 1 = subthreshold)
//     load_i                 request to push the staged banks into the cascade
//     busy_o, done_o         sequence in progress / one-cycle completion pulse
//     thresh_o               {sub, thr} cascade data
//     thresh_wr_o            shift strobes, bit 0 = thr, bit 1 = sub
//     thresh_update_o        commit strobes, same bit mapping
//     rb_sel_i/rb_addr_i     staging readback select and address
//     rb_dat_o               staging readback data
module thresh_loader #(
  parameter int NBEAMS      = 2,
  parameter int THRESH_BITS = 18
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       stg_wr_i,
  input  logic                       stg_sel_i,
  input  logic [$clog2(NBEAMS)-1:0]  stg_addr_i,
  input  logic [THRESH_BITS-1:0]     stg_dat_i,
  input  logic                       load_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [2*THRESH_BITS-1:0]   thresh_o,
  output logic [1:0]                 thresh_wr_o,
  output logic [1:0]                 thresh_update_o,
  input  logic                       rb_sel_i,
  input  logic [$clog2(NBEAMS)-1:0]  rb_addr_i,
  output logic [THRESH_BITS-1:0]     rb_dat_o
);
  localparam int AW = $clog2(NBEAMS);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE, DONE} state_t;

  state_t                                state_q, state_d;
  logic [AW-1:0]                         cnt_q, cnt_d;
  logic                                  pend_q, pend_d;
  logic [NBEAMS-1:0][THRESH_BITS-1:0]    thr_q, thr_d, sub_q, sub_d;
  logic                                  wr_ok, busy, pend_set;

  assign wr_ok = stg_wr_i && (int'(stg_addr_i) < NBEAMS);

  // Staging banks. They have no reset, so staged data survives an aborted
  // sequence.
  always_comb begin
    thr_d = thr_q;
    sub_d = sub_q;
    if (wr_ok) begin
      if (stg_sel_i) sub_d[stg_addr_i] = stg_dat_i;
      else           thr_d[stg_addr_i] = stg_dat_i;
    end
  end

  always_ff @(posedge aclk) begin
    thr_q <= thr_d;
    sub_q <= sub_d;
  end

  // A load request or a staging write that arrives mid-sequence leaves the
  // cascade stale, so either one queues a single follow-up pass.
  assign busy     = (state_q != IDLE);
  assign pend_set = busy && (load_i || wr_ok);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pend_d          = pend_q | pend_set;
    busy_o          = busy;
    done_o          = 1'b0;
    thresh_o        = '0;
    thresh_wr_o     = 2'b00;
    thresh_update_o = 2'b00;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          state_d = SHIFT;
          cnt_d   = AW'(NBEAMS - 1);
        end
      end
      SHIFT: begin
        // The banks are read from flops, so a write to the same entry in this
        // cycle is not seen until the next pass.
        thresh_wr_o = 2'b11;
        thresh_o    = {sub_q[cnt_q], thr_q[cnt_q]};
        if (cnt_q == '0) state_d = UPDATE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      UPDATE: begin
        thresh_update_o = 2'b11;
        state_d         = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        // A request that lands in this cycle is folded into the immediate
        // restart so that it is never lost.
        if (pend_q || pend_set) begin
          state_d = SHIFT;
          cnt_d   = AW'(NBEAMS - 1);
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

`ifdef THRESH_LOADER_READBACK_EN
  logic [THRESH_BITS-1:0] rb_q, rb_d;

  always_comb begin
    rb_d = '0;
    if (int'(rb_addr_i) < NBEAMS)
      rb_d = rb_sel_i ? sub_q[rb_addr_i] : thr_q[rb_addr_i];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rb_q <= '0;
    else          rb_q <= rb_d;
  end

  assign rb_dat_o = rb_q;
`else
  logic unused_rb;
  assign unused_rb = ^{rb_sel_i, rb_addr_i};
  assign rb_dat_o  = '0;
`endif

endmodule

// File: tb/tb_thresh_loader.sv
module tb_thresh_loader;
  logic aclk;
  logic aresetn;

  // DUT A: NBEAMS=2
  logic        a_wr, a_sel, a_load, a_rb_sel;
  logic [0:0]  a_addr, a_rb_addr;
  logic [17:0] a_dat, a_rb;
  logic        a_busy, a_done;
  logic [35:0] a_th;
  logic [1:0]  a_twr, a_upd;

  // DUT B: NBEAMS=46
  logic        b_wr, b_sel, b_load, b_rb_sel;
  logic [5:0]  b_addr, b_rb_addr;
  logic [17:0] b_dat, b_rb;
  logic        b_busy, b_done;
  logic [35:0] b_th;
  logic [1:0]  b_twr, b_upd;

  int checks   = 0;
  int failures = 0;

  thresh_loader #(.NBEAMS(2), .THRESH_BITS(18)) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .stg_wr_i(a_wr), .stg_sel_i(a_sel), .stg_addr_i(a_addr), .stg_dat_i(a_dat),
    .load_i(a_load), .busy_o(a_busy), .done_o(a_done),
    .thresh_o(a_th), .thresh_wr_o(a_twr), .thresh_update_o(a_upd),
    .rb_sel_i(a_rb_sel), .rb_addr_i(a_rb_addr), .rb_dat_o(a_rb)
  );

  thresh_loader #(.NBEAMS(46), .THRESH_BITS(18)) u_dut46 (
    .aclk(aclk), .aresetn(aresetn),
    .stg_wr_i(b_wr), .stg_sel_i(b_sel), .stg_addr_i(b_addr), .stg_dat_i(b_dat),
    .load_i(b_load), .busy_o(b_busy), .done_o(b_done),
    .thresh_o(b_th), .thresh_wr_o(b_twr), .thresh_update_o(b_upd),
    .rb_sel_i(b_rb_sel), .rb_addr_i(b_rb_addr), .rb_dat_o(b_rb)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  function automatic logic [35:0] pk(input int s, input int t);
    logic [17:0] s18, t18;
    s18 = s[17:0];
    t18 = t[17:0];
    return {s18, t18};
  endfunction

  task automatic a_write(input logic sel, input logic [0:0] addr, input logic [17:0] dat);
    a_wr = 1'b1; a_sel = sel; a_addr = addr; a_dat = dat;
    tick();
    a_wr = 1'b0;
  endtask

  task automatic b_write(input logic sel, input logic [5:0] addr, input logic [17:0] dat);
    b_wr = 1'b1; b_sel = sel; b_addr = addr; b_dat = dat;
    tick();
    b_wr = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    a_wr = 0; a_sel = 0; a_addr = 0; a_dat = 0; a_load = 0; a_rb_sel = 0; a_rb_addr = 0;
    b_wr = 0; b_sel = 0; b_addr = 0; b_dat = 0; b_load = 0; b_rb_sel = 0; b_rb_addr = 0;
    tick(); tick();
    // reset state
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_th", a_th, 0);
    chk("rst_twr", a_twr, 0);
    chk("rst_upd", a_upd, 0);
    chk("rst_rb", a_rb, 0);
    aresetn = 1'b1;
    tick();

    // basic 2-beam sequence
    a_write(0, 0, 18'h100);
    a_write(0, 1, 18'h101);
    a_write(1, 0, 18'h200);
    a_write(1, 1, 18'h201);
    chk("idle_after_writes", a_busy, 0);
    a_load = 1; tick(); a_load = 0;
    chk("s1_twr", a_twr, 2'b11);
    chk("s1_th", a_th, pk('h201, 'h101));
    chk("s1_busy", a_busy, 1);
    chk("s1_upd", a_upd, 0);
    tick();
    chk("s2_twr", a_twr, 2'b11);
    chk("s2_th", a_th, pk('h200, 'h100));
    tick();
    chk("u_upd", a_upd, 2'b11);
    chk("u_twr", a_twr, 0);
    chk("u_th", a_th, 0);
    chk("u_done", a_done, 0);
    tick();
    chk("d_done", a_done, 1);
    chk("d_busy", a_busy, 1);
    chk("d_upd", a_upd, 0);
    tick();
    chk("i_done", a_done, 0);
    chk("i_busy", a_busy, 0);
    chk("i_twr", a_twr, 0);

    // three loads during busy coalesce into one back-to-back reload
    a_load = 1; tick();
    chk("c_s1", a_twr, 2'b11);
    tick();
    chk("c_s2", a_twr, 2'b11);
    tick(); a_load = 0;
    chk("c_u", a_upd, 2'b11);
    tick();
    chk("c_d", a_done, 1);
    tick();
    chk("c_r_twr", a_twr, 2'b11);
    chk("c_r_th", a_th, pk('h201, 'h101));
    chk("c_r_done", a_done, 0);
    chk("c_r_busy", a_busy, 1);
    tick();
    chk("c_r_s2", a_th, pk('h200, 'h100));
    tick();
    chk("c_r_u", a_upd, 2'b11);
    tick();
    chk("c_r_d", a_done, 1);
    tick();
    chk("c_idle_busy", a_busy, 0);
    chk("c_idle_twr", a_twr, 0);

    // staging write to beam 0 in the same cycle SHIFT reads beam 0
    a_load = 1; tick(); a_load = 0;
    chk("w_s1", a_th, pk('h201, 'h101));
    tick();
    a_wr = 1; a_sel = 0; a_addr = 0; a_dat = 18'h1AA;
    chk("w_s2_old", a_th, pk('h200, 'h100));
    tick(); a_wr = 0;
    chk("w_u", a_upd, 2'b11);
    tick();
    chk("w_d", a_done, 1);
    tick();
    chk("w_r1", a_th, pk('h201, 'h101));
    tick();
    chk("w_r2_new", a_th, pk('h200, 'h1AA));
    tick();
    chk("w_r_u", a_upd, 2'b11);
    tick();
    chk("w_r_d", a_done, 1);
    tick();
    chk("w_idle", a_busy, 0);

    // asynchronous reset in the first SHIFT cycle
    a_load = 1; tick(); a_load = 0;
    chk("r_s1", a_twr, 2'b11);
    #2 aresetn = 1'b0;
    #1;
    chk("r_async_twr", a_twr, 0);
    chk("r_async_th", a_th, 0);
    chk("r_async_busy", a_busy, 0);
    chk("r_async_upd", a_upd, 0);
    chk("r_async_done", a_done, 0);
    tick(); tick();
    chk("r_held_upd", a_upd, 0);
    aresetn = 1'b1;
    tick();
    chk("r_post_busy", a_busy, 0);
    a_load = 1; tick(); a_load = 0;
    chk("r_again1", a_th, pk('h201, 'h101));
    tick();
    chk("r_again2", a_th, pk('h200, 'h1AA));
    tick();
    chk("r_again_u", a_upd, 2'b11);
    tick();
    chk("r_again_d", a_done, 1);
    tick();

`ifndef THRESH_LOADER_READBACK_EN
    chk("rb_tied_a", a_rb, 0);
`endif

    // 46-beam instance
    for (int i = 0; i < 46; i++) begin
      b_write(0, 6'(i), 18'(32'h3000 + i));
      b_write(1, 6'(i), 18'(32'h2000 + i));
    end
    b_write(0, 6'd50, 18'h3FFFF);
    b_write(0, 6'd45, 18'h12345);
`ifdef THRESH_LOADER_READBACK_EN
    b_rb_sel = 0; b_rb_addr = 6'd45; tick();
    chk("rb_45", b_rb, 18'h12345);
    b_rb_sel = 1; b_rb_addr = 6'd7; tick();
    chk("rb_sub7", b_rb, 18'h2007);
    b_rb_sel = 0; b_rb_addr = 6'd50; tick();
    chk("rb_oor", b_rb, 0);
`else
    b_rb_sel = 0; b_rb_addr = 6'd45; tick();
    chk("rb_tied_b", b_rb, 0);
`endif
    chk("b_idle", b_busy, 0);
    b_load = 1; tick(); b_load = 0;
    // out-of-range write while busy must not queue a reload
    b_wr = 1; b_sel = 0; b_addr = 6'd50; b_dat = 18'h0;
    for (int i = 45; i >= 0; i--) begin
      chk("b_twr", b_twr, 2'b11);
      chk("b_th", b_th, pk(32'h2000 + i, (i == 45) ? 32'h12345 : 32'h3000 + i));
      tick();
      b_wr = 0;
    end
    chk("b_upd", b_upd, 2'b11);
    chk("b_twr_off", b_twr, 0);
    tick();
    chk("b_done", b_done, 1);
    tick();
    chk("b_no_reload", b_busy, 0);
    chk("b_done_clr", b_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
